// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage ram_* interface.
// Accepts one word read and/or write from IDLE, waits a fixed LATENCY, then
// performs the access against an internal word array. The response is a
// single-cycle ram_ready_o strobe, with ram_err_o marking an out-of-range address.
module data_ram_resp #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter int              LATENCY     = 3,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] ram_addr_i,
  input  logic [XLEN-1:0] ram_data_i,
  input  logic            ram_we_i,
  input  logic            ram_re_i,
  output logic [XLEN-1:0] ram_data_o,
  output logic            ram_ready_o,
  output logic            ram_err_o
);

  localparam int              AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0]      CNT_LOAD = 3'(LATENCY - 1);
  localparam logic [XLEN-1:0] DEPTH_X  = XLEN'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [2:0]      cnt, cnt_next;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic            re_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            fire;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] word_off;
  logic [AW-1:0]   idx;
  logic            in_range;

  // A request is only taken from IDLE; fire marks the edge that enters RESP.
  assign accept   = (state == IDLE) && (ram_re_i || ram_we_i);
  assign fire     = (state == BUSY) && (cnt == 3'd0);

  // Addresses below BASE_ADDR wrap to a huge offset; the explicit >= compare
  // rejects them so the wrap can never alias onto a valid word.
  assign offset   = addr_q - BASE_ADDR;
  assign word_off = offset >> 2;
  assign idx      = word_off[AW-1:0];
  assign in_range = (addr_q >= BASE_ADDR) && (word_off < DEPTH_X);

  // Next-state and wait-counter logic. The counter holds the number of
  // further BUSY edges before the response edge, so RESP is entered exactly
  // LATENCY edges after the accept edge (LATENCY==1 spends no extra BUSY edge).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ram_re_i || ram_we_i) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 3'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request on the accept edge so single-cycle pulses suffice.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= ram_addr_i;
      wdata_q <= ram_data_i;
      we_q    <= ram_we_i;
      re_q    <= ram_re_i;
    end
  end

  // Response registers: strobe, error flag and read data (old word on re&we).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_ready_o <= 1'b0;
      ram_err_o   <= 1'b0;
      ram_data_o  <= '0;
    end else begin
      ram_ready_o <= fire;
      ram_err_o   <= fire && !in_range;
      if (fire && re_q) begin
        ram_data_o <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (fire && we_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
